// File: rtl/fir_transposed_prog_if.sv
// ---------------------------------------------------------------------------
// fir_transposed_prog_if: sample, coefficient-programming and result bundle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface fir_transposed_prog_if #(
   parameter int DATA_W = 8,
   parameter int COEF_W = 8,
   parameter int TAPS   = 10,
   parameter int OUT_W  = 16
);
   localparam int ADDR_W = $clog2(TAPS);

   logic                     in_valid;
   logic signed [DATA_W-1:0] in_data;
   logic                     coef_we;
   logic [ADDR_W-1:0]        coef_addr;
   logic signed [COEF_W-1:0] coef_data;
   logic                     coef_commit;
   logic                     out_valid;
   logic signed [OUT_W-1:0]  out_data;
   logic                     out_primed;

   modport master (
      output in_valid, in_data, coef_we, coef_addr, coef_data, coef_commit,
      input  out_valid, out_data, out_primed
   );

   modport slave (
      input  in_valid, in_data, coef_we, coef_addr, coef_data, coef_commit,
      output out_valid, out_data, out_primed
   );
endinterface

`default_nettype wire

// File: rtl/fir_transposed_prog.sv
// ---------------------------------------------------------------------------
// fir_transposed_prog: transposed-form FIR with shadow/active coefficient banks.
// Define FIR_OUT_SAT_EN to clamp the output instead of wrapping.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fir_transposed_prog #(
   parameter int DATA_W = 8,
   parameter int COEF_W = 8,
   parameter int TAPS   = 10,
   parameter int OUT_W  = 16
) (
   input  wire logic                    clk,
   input  wire logic                    reset,
   fir_transposed_prog_if.slave         bus
);
   localparam int ACC_W  = DATA_W + COEF_W + $clog2(TAPS);
   localparam int ADDR_W = $clog2(TAPS);
   localparam int CNT_W  = $clog2(TAPS + 1);
   localparam logic [ADDR_W:0]  C_TAPS_A = (ADDR_W + 1)'(TAPS);
   localparam logic [CNT_W-1:0] C_TAPS_C = CNT_W'(TAPS);

   logic signed [COEF_W-1:0] shadow_q [TAPS];
   logic signed [COEF_W-1:0] shadow_d [TAPS];
   logic signed [COEF_W-1:0] active_q [TAPS];
   logic signed [COEF_W-1:0] active_d [TAPS];
   logic signed [ACC_W-1:0]  p_q      [TAPS-1];
   logic signed [ACC_W-1:0]  p_d      [TAPS-1];
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic                     out_valid_q, out_valid_d;
   logic signed [OUT_W-1:0]  out_data_q, out_data_d;

   logic signed [ACC_W-1:0]  w_x_ext;
   logic signed [ACC_W-1:0]  w_prod   [TAPS];
   logic signed [ACC_W-1:0]  w_acc;
   logic signed [OUT_W-1:0]  w_out_sel;
   logic                     w_addr_ok;

   assign w_x_ext   = {{(ACC_W-DATA_W){bus.in_data[DATA_W-1]}}, bus.in_data};
   assign w_addr_ok = ({1'b0, bus.coef_addr} < C_TAPS_A);

   // Operands are sign-extended to ACC_W so the low ACC_W product bits are exact.
   generate
      for (genvar k = 0; k < TAPS; k++) begin : g_tap
         logic signed [ACC_W-1:0] w_coef_ext;
         assign w_coef_ext = {{(ACC_W-COEF_W){active_q[k][COEF_W-1]}}, active_q[k]};
         assign w_prod[k]  = w_coef_ext * w_x_ext;
      end
   endgenerate

   assign w_acc = w_prod[0] + p_q[0];

`ifdef FIR_OUT_SAT_EN
   localparam logic signed [ACC_W-1:0] C_OUT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] C_OUT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   always_comb begin
      w_out_sel = w_acc[OUT_W-1:0];
      if (w_acc > C_OUT_MAX) begin
         w_out_sel = C_OUT_MAX[OUT_W-1:0];
      end else if (w_acc < C_OUT_MIN) begin
         w_out_sel = C_OUT_MIN[OUT_W-1:0];
      end
   end
`else
   assign w_out_sel = w_acc[OUT_W-1:0];

   // Upper accumulator bits are deliberately discarded in the wrapping build.
   generate
      if (OUT_W < ACC_W) begin : g_wrap_hi
         logic w_unused_acc_hi;
         assign w_unused_acc_hi = ^w_acc[ACC_W-1:OUT_W];
      end
   endgenerate
`endif

   always_comb begin
      shadow_d = shadow_q;
      if (bus.coef_we && w_addr_ok) begin
         shadow_d[bus.coef_addr] = bus.coef_data;
      end
      // Commit sees this cycle's write, and lands after this cycle's sample.
      active_d = bus.coef_commit ? shadow_d : active_q;

      p_d         = p_q;
      cnt_d       = cnt_q;
      out_valid_d = bus.in_valid;
      out_data_d  = out_data_q;
      if (bus.in_valid) begin
         p_d[TAPS-2] = w_prod[TAPS-1];
         for (int k = 0; k < TAPS - 2; k++) begin
            p_d[k] = w_prod[k+1] + p_q[k+1];
         end
         out_data_d = w_out_sel;
         if (cnt_q != C_TAPS_C) begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < TAPS; k++) begin
            shadow_q[k] <= '0;
            active_q[k] <= '0;
         end
         for (int k = 0; k < TAPS - 1; k++) begin
            p_q[k] <= '0;
         end
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         shadow_q    <= shadow_d;
         active_q    <= active_d;
         p_q         <= p_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   assign bus.out_valid  = out_valid_q;
   assign bus.out_data   = out_data_q;
   assign bus.out_primed = (cnt_q == C_TAPS_C);

endmodule

`default_nettype wire
